// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN accelerator datapath.
//   DATA_W     : pixel width (signed int8)
//   LANES      : pixels carried per stream beat
//   pix_t      : one signed pixel
//   lane_vec_t : one beat, LANES x pix_t, lane 1 at index 0
//   relu_vec   : per-lane ReLU
//   max_vec    : per-lane signed maximum, no width growth
package cnn_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef pix_t [LANES-1:0]         lane_vec_t;

  function automatic pix_t relu_pix(input pix_t x);
    return x[DATA_W-1] ? {DATA_W{1'b0}} : x;
  endfunction

  function automatic pix_t max_pix(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic lane_vec_t relu_vec(input lane_vec_t v);
    lane_vec_t r;
    for (int i = 0; i < LANES; i++) begin
      r[i] = relu_pix(v[i]);
    end
    return r;
  endfunction

  function automatic lane_vec_t max_vec(input lane_vec_t a, input lane_vec_t b);
    lane_vec_t r;
    for (int i = 0; i < LANES; i++) begin
      r[i] = max_pix(a[i], b[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer for the 2x2 pooler: stores the horizontal max of
// each even-row pixel pair until the matching odd row arrives.
//   clk   : clock
//   we    : write enable
//   waddr : write entry (pooled column)
//   wdata : 4-lane partial maximum
//   raddr : read entry, read is combinational
//   rdata : stored partial
// Contents are deliberately not reset; every entry is rewritten on each
// even row before it is read.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  lane_vec_t       wdata,
  input  logic [AW-1:0]   raddr,
  output lane_vec_t       rdata
);

  lane_vec_t mem_r [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster IMG_W x IMG_H
// map of 4-lane int8 beats. One pooled beat is emitted per 2x2 window,
// one cycle after the odd-row/odd-column input beat is accepted.
//   clk, rst          : clock, synchronous active-high reset
//   clear_i           : restart frame position (drops a coincident beat)
//   valid_i, data_i_* : input beat, no backpressure
//   valid_o, data_o_* : pooled beat (data holds between pulses)
//   pool_done         : pulses with the last pooled beat of a frame
module relu_maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_i_1,
  input  logic signed [DATA_W-1:0] data_i_2,
  input  logic signed [DATA_W-1:0] data_i_3,
  input  logic signed [DATA_W-1:0] data_i_4,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] data_o_1,
  output logic signed [DATA_W-1:0] data_o_2,
  output logic signed [DATA_W-1:0] data_o_3,
  output logic signed [DATA_W-1:0] data_o_4,
  output logic                     pool_done
);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("relu_maxpool_2x2: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("relu_maxpool_2x2: IMG_H must be even and >= 2");
  end

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  lane_vec_t     hold_r;
  logic          valid_r;
  lane_vec_t     data_r;
  logic          done_r;

  lane_vec_t     in_s;
  lane_vec_t     relu_s;
  lane_vec_t     hmax_s;
  lane_vec_t     omax_s;
  lane_vec_t     lb_rdata_s;
  logic [AW-1:0] lb_addr_s;
  logic          lb_we_s;

  // Input lanes, ReLU and the two-level compare tree
  always_comb begin
    in_s[0]   = data_i_1;
    in_s[1]   = data_i_2;
    in_s[2]   = data_i_3;
    in_s[3]   = data_i_4;
    relu_s    = relu_vec(in_s);
    hmax_s    = max_vec(hold_r, relu_s);
    omax_s    = max_vec(lb_rdata_s, hmax_s);
    lb_addr_s = AW'(col_r >> 1);
    // clear_i drops a coincident beat, so it must not touch the buffer either
    lb_we_s   = valid_i & ~clear_i & col_r[0] & ~row_r[0];
  end

  pool_line_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we_s),
    .waddr (lb_addr_s),
    .wdata (hmax_s),
    .raddr (lb_addr_s),
    .rdata (lb_rdata_s)
  );

  // Frame position, horizontal hold register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r   <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
      hold_r  <= {(LANES*DATA_W){1'b0}};
      valid_r <= 1'b0;
      data_r  <= {(LANES*DATA_W){1'b0}};
      done_r  <= 1'b0;
    end else if (clear_i) begin
      col_r   <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
      hold_r  <= {(LANES*DATA_W){1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      if (valid_i) begin
        if (!col_r[0]) begin
          hold_r <= relu_s;
        end else if (row_r[0]) begin
          valid_r <= 1'b1;
          data_r  <= omax_s;
          done_r  <= (row_r == ROW_LAST) && (col_r == COL_LAST);
        end
        if (col_r == COL_LAST) begin
          col_r <= {CW{1'b0}};
          row_r <= (row_r == ROW_LAST) ? {RW{1'b0}} : row_r + 1'b1;
        end else begin
          col_r <= col_r + 1'b1;
        end
      end
    end
  end

  assign valid_o   = valid_r;
  assign data_o_1  = data_r[0];
  assign data_o_2  = data_r[1];
  assign data_o_3  = data_r[2];
  assign data_o_4  = data_r[3];
  assign pool_done = done_r;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed bench for relu_maxpool_2x2. A 4x2 instance covers the
// hand-computed cases; a 32x32 instance shares the same input stream and
// is checked against a 2-D reference model for back-to-back frames.
module tb_relu_maxpool_2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] din = 32'h0;

  always #5 clk = ~clk;

  logic              valid_o_s, done_s, valid_o_l, done_l;
  logic signed [7:0] d_s1, d_s2, d_s3, d_s4, d_l1, d_l2, d_l3, d_l4;
  logic [31:0]       dout_s, dout_l;

  assign dout_s = {d_s1, d_s2, d_s3, d_s4};
  assign dout_l = {d_l1, d_l2, d_l3, d_l4};

  relu_maxpool_2x2 #(.IMG_W(4), .IMG_H(2)) dut_s (
    .clk(clk), .rst(rst), .clear_i(clear_i), .valid_i(valid_i),
    .data_i_1(din[31:24]), .data_i_2(din[23:16]), .data_i_3(din[15:8]), .data_i_4(din[7:0]),
    .valid_o(valid_o_s), .data_o_1(d_s1), .data_o_2(d_s2), .data_o_3(d_s3), .data_o_4(d_s4),
    .pool_done(done_s)
  );

  relu_maxpool_2x2 #(.IMG_W(32), .IMG_H(32)) dut_l (
    .clk(clk), .rst(rst), .clear_i(clear_i), .valid_i(valid_i),
    .data_i_1(din[31:24]), .data_i_2(din[23:16]), .data_i_3(din[15:8]), .data_i_4(din[7:0]),
    .valid_o(valid_o_l), .data_o_1(d_l1), .data_o_2(d_l2), .data_o_3(d_l3), .data_o_4(d_l4),
    .pool_done(done_l)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fr [8];
  logic [31:0] img [32][32];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // lanes: x, 100-x, -x, 3x
  function automatic logic [31:0] mk(input int x);
    logic [7:0] a, b, c, d;
    a = 8'(x);
    b = 8'(100 - x);
    c = 8'(-x);
    d = 8'(3 * x);
    return {a, b, c, d};
  endfunction

  function automatic logic [7:0] relu8(input logic [7:0] x);
    return x[7] ? 8'd0 : x;
  endfunction

  function automatic logic [31:0] pool_exp(input int r, input int c);
    logic [31:0] e;
    logic [7:0]  m, v;
    e = 32'h0;
    for (int ln = 0; ln < 4; ln++) begin
      m = 8'd0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          v = relu8(img[r+dr][c+dc][31-8*ln -: 8]);
          if (v > m) m = v;
        end
      end
      e[31-8*ln -: 8] = m;
    end
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d, input logic clr);
    valid_i = v;
    din     = d;
    clear_i = clr;
    @(posedge clk);
    #1;
  endtask

  // Feed fr[] as one 4x2 frame into the small instance and check every cycle
  task automatic run_small(input bit gaps, input logic [31:0] e0, input logic [31:0] e1, input string tag);
    int          nout;
    logic [31:0] last;
    nout = 0;
    last = 32'h0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, fr[i], 1'b0);
      if (valid_o_s) nout++;
      if (i == 5 || i == 7) begin
        last = (i == 5) ? e0 : e1;
        check_val($sformatf("%s_valid%0d", tag, i), 32'(valid_o_s), 32'd1);
        check_val($sformatf("%s_data%0d", tag, i), dout_s, last);
        check_val($sformatf("%s_done%0d", tag, i), 32'(done_s), (i == 7) ? 32'd1 : 32'd0);
      end else begin
        check_val($sformatf("%s_valid%0d", tag, i), 32'(valid_o_s), 32'd0);
        check_val($sformatf("%s_done%0d", tag, i), 32'(done_s), 32'd0);
      end
      if (gaps) begin
        for (int g = 0; g < (i % 4); g++) begin
          cyc(1'b0, 32'h0, 1'b0);
          if (valid_o_s) nout++;
          check_val($sformatf("%s_gapvalid%0d_%0d", tag, i, g), 32'(valid_o_s), 32'd0);
          if (i >= 5) check_val($sformatf("%s_gapdata%0d_%0d", tag, i, g), dout_s, last);
        end
      end
    end
    check_val($sformatf("%s_nout", tag), 32'(nout), 32'd2);
  endtask

  task automatic load_test2();
    for (int i = 0; i < 8; i++) fr[i] = mk(i + 1);
  endtask

  initial begin
    int outs, dones, unexp;

    // 1: reset with random activity on the inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'b0);
      check_val("rst_valid_s", 32'(valid_o_s), 32'd0);
      check_val("rst_done_s", 32'(done_s), 32'd0);
      check_val("rst_data_s", dout_s, 32'h0);
      check_val("rst_valid_l", 32'(valid_o_l), 32'd0);
      check_val("rst_done_l", 32'(done_l), 32'd0);
      check_val("rst_data_l", dout_l, 32'h0);
    end
    rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);

    // 2: basic 4x2 frame; windows {1,2,5,6} and {3,4,7,8}
    load_test2();
    run_small(1'b0, 32'h06630012, 32'h08610018, "basic");

    // 3: ReLU, all-negative window then mixed window
    fr[0] = 32'hFBFBFBFB; fr[1] = 32'hFDFDFDFD; fr[2] = 32'hFBFBFBFB; fr[3] = 32'h07070707;
    fr[4] = 32'hFFFFFFFF; fr[5] = 32'h80808080; fr[6] = 32'hFFFFFFFF; fr[7] = 32'h02020202;
    run_small(1'b0, 32'h00000000, 32'h07070707, "relu");

    // 4: same stream as test 2 with 0..3 idle cycles between beats
    load_test2();
    run_small(1'b1, 32'h06630012, 32'h08610018, "gaps");

    // 5: clear after 3 beats; the beat presented with clear_i is dropped
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h78787878, 1'b0);
    cyc(1'b1, 32'h7F7F7F7F, 1'b1);
    check_val("clr_valid", 32'(valid_o_s), 32'd0);
    run_small(1'b0, 32'h06630012, 32'h08610018, "clr");

    // 6: two back-to-back random 32x32 frames on the large instance
    cyc(1'b0, 32'h0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) img[r][c] = $urandom;
      outs  = 0;
      dones = 0;
      unexp = 0;
      for (int r = 0; r < 32; r++) begin
        for (int c = 0; c < 32; c++) begin
          cyc(1'b1, img[r][c], 1'b0);
          if (valid_o_l) outs++;
          if (done_l) dones++;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            check_val($sformatf("big_valid_f%0d_r%0d_c%0d", f, r, c), 32'(valid_o_l), 32'd1);
            check_val($sformatf("big_data_f%0d_r%0d_c%0d", f, r, c), dout_l, pool_exp(r - 1, c - 1));
            check_val($sformatf("big_done_f%0d_r%0d_c%0d", f, r, c), 32'(done_l),
                      (r == 31 && c == 31) ? 32'd1 : 32'd0);
          end else if (valid_o_l || done_l) begin
            unexp++;
          end
        end
      end
      check_val($sformatf("big_nout_f%0d", f), 32'(outs), 32'd256);
      check_val($sformatf("big_ndone_f%0d", f), 32'(dones), 32'd1);
      check_val($sformatf("big_unexpected_f%0d", f), 32'(unexp), 32'd0);
    end
    cyc(1'b0, 32'h0, 1'b0);
    check_val("big_idle_valid", 32'(valid_o_l), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
